// File: rtl/clkgen_rate_sequencer.sv
// Run-time sample-rate sequencer for the SPI clock generator: index -> M/D, program trigger, PROGDONE/LOCKED handshake with timeout/retry.
// Optional CLKGEN_CUSTOM_MD_EN: index 31 takes range-checked M_custom/D_custom.
module clkgen_rate_sequencer #(
  parameter int DEFAULT_IDX    = 16,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int LOCK_STABLE    = 16,
  parameter int MAX_RETRY      = 2
) (
  input  logic       ti_clk,
  input  logic       reset,
  input  logic [4:0] rate_sel,
  input  logic       rate_go,
  input  logic [8:0] M_custom,
  input  logic [8:0] D_custom,
  input  logic       prog_done_in,
  input  logic       locked_in,
  output logic [8:0] M_out,
  output logic [8:0] D_out,
  output logic       prog_trigger,
  output logic       busy,
  output logic       hold_acq,
  output logic       done_pulse,
  output logic       error,
  output logic [4:0] cur_rate
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int LW = $clog2(LOCK_STABLE + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_TRIG, S_WAIT_PLO, S_WAIT_PHI, S_WAIT_LOCK, S_DONE, S_ERROR
  } state_t;

  function automatic logic [17:0] rate_md(input logic [4:0] idx);
    case (idx)
      5'd0:    rate_md = {9'd7,   9'd125};
      5'd1:    rate_md = {9'd7,   9'd100};
      5'd2:    rate_md = {9'd21,  9'd250};
      5'd3:    rate_md = {9'd14,  9'd125};
      5'd4:    rate_md = {9'd35,  9'd250};
      5'd5:    rate_md = {9'd21,  9'd125};
      5'd6:    rate_md = {9'd14,  9'd75};
      5'd7:    rate_md = {9'd28,  9'd125};
      5'd8:    rate_md = {9'd7,   9'd25};
      5'd9:    rate_md = {9'd7,   9'd20};
      5'd10:   rate_md = {9'd112, 9'd250};
      5'd11:   rate_md = {9'd14,  9'd25};
      5'd12:   rate_md = {9'd7,   9'd10};
      5'd13:   rate_md = {9'd21,  9'd25};
      5'd14:   rate_md = {9'd28,  9'd25};
      5'd15:   rate_md = {9'd35,  9'd25};
      5'd16:   rate_md = {9'd42,  9'd25};
      5'd17:   rate_md = {9'd28,  9'd15};
      5'd18:   rate_md = {9'd56,  9'd25};
      5'd19:   rate_md = {9'd14,  9'd5};
      default: rate_md = {9'd42,  9'd25};
    endcase
  endfunction

  localparam logic [17:0] DEF_MD = rate_md(5'(DEFAULT_IDX));

  state_t          state, state_nx;
  logic            pd_m, pd_s, lk_m, lk_s;
  logic [TW-1:0]   timer;
  logic [LW-1:0]   lock_cnt;
  logic [RW-1:0]   retry;
  logic [4:0]      idx_q;
  logic            req_ok;
  logic [8:0]      req_m, req_d;
  logic            wait_st, timeout;

  always_comb begin
    req_ok = (rate_sel < 5'd20);
    {req_m, req_d} = rate_md(rate_sel);
`ifdef CLKGEN_CUSTOM_MD_EN
    if (rate_sel == 5'd31) begin
      req_m  = M_custom;
      req_d  = D_custom;
      req_ok = (M_custom >= 9'd2) && (M_custom <= 9'd256) &&
               (D_custom >= 9'd1) && (D_custom <= 9'd256) &&
               (14'(M_custom) * 14'd20 >= 14'(D_custom)) &&
               (14'(M_custom) * 14'd3 <= 14'(D_custom) * 14'd10);
    end
`endif
  end

`ifndef CLKGEN_CUSTOM_MD_EN
  logic unused_custom;
  assign unused_custom = ^{M_custom, D_custom};
`endif

  always_ff @(posedge ti_clk) begin
    if (reset) {pd_m, pd_s, lk_m, lk_s} <= 4'b0;
    else begin
      pd_m <= prog_done_in;
      pd_s <= pd_m;
      lk_m <= locked_in;
      lk_s <= lk_m;
    end
  end

  assign wait_st = (state == S_WAIT_PLO) || (state == S_WAIT_PHI) || (state == S_WAIT_LOCK);
  assign timeout = wait_st && (timer == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_nx     = state;
    prog_trigger = 1'b0;
    busy         = 1'b1;
    done_pulse   = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (rate_go) state_nx = req_ok ? S_LOAD : S_ERROR;
      end
      S_LOAD: state_nx = S_TRIG;
      S_TRIG: begin
        prog_trigger = 1'b1;
        state_nx     = S_WAIT_PLO;
      end
      S_WAIT_PLO: if (!pd_s) state_nx = S_WAIT_PHI;
      S_WAIT_PHI: if (pd_s) state_nx = S_WAIT_LOCK;
      S_WAIT_LOCK: if (lk_s && lock_cnt == LW'(LOCK_STABLE - 1)) state_nx = S_DONE;
      S_DONE: begin
        done_pulse = 1'b1;
        state_nx   = S_IDLE;
      end
      S_ERROR: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    // Progress on the same cycle as a timeout wins over the retry.
    if (timeout && state_nx == state)
      state_nx = (retry == RW'(MAX_RETRY)) ? S_ERROR : S_TRIG;
  end

  assign hold_acq = busy;

  always_ff @(posedge ti_clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // M/D are captured on acceptance so they are already stable for the whole LOAD cycle.
  always_ff @(posedge ti_clk) begin
    if (reset) begin
      M_out    <= DEF_MD[17:9];
      D_out    <= DEF_MD[8:0];
      cur_rate <= 5'(DEFAULT_IDX);
      idx_q    <= 5'(DEFAULT_IDX);
      error    <= 1'b0;
      retry    <= '0;
      timer    <= '0;
      lock_cnt <= '0;
    end else begin
      if (state == S_IDLE && rate_go && req_ok) begin
        M_out <= req_m;
        D_out <= req_d;
        idx_q <= rate_sel;
        error <= 1'b0;
      end
      if (state_nx == S_ERROR) error <= 1'b1;
      if (state == S_LOAD) retry <= '0;
      else if (wait_st && state_nx == S_TRIG) retry <= retry + 1'b1;
      if (state == S_DONE) cur_rate <= idx_q;
      if (state_nx != state || state == S_LOAD) timer <= '0;
      else if (wait_st) timer <= timer + 1'b1;
      if (state != S_WAIT_LOCK || !lk_s) lock_cnt <= '0;
      else lock_cnt <= lock_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_clkgen_rate_sequencer.sv
// Bench for clkgen_rate_sequencer: clock-generator model, hand-written corner sequences, then a scoreboarded vector table.
module tb_clkgen_rate_sequencer;
  logic       ti_clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] rate_sel = '0;
  logic       rate_go = 1'b0;
  logic [8:0] M_custom = '0, D_custom = '0;
  logic       prog_done_in = 1'b1, locked_in = 1'b1;
  logic [8:0] M_out, D_out;
  logic       prog_trigger, busy, hold_acq, done_pulse, error;
  logic [4:0] cur_rate;

  clkgen_rate_sequencer dut (
    .ti_clk(ti_clk), .reset(reset), .rate_sel(rate_sel), .rate_go(rate_go),
    .M_custom(M_custom), .D_custom(D_custom), .prog_done_in(prog_done_in),
    .locked_in(locked_in), .M_out(M_out), .D_out(D_out), .prog_trigger(prog_trigger),
    .busy(busy), .hold_acq(hold_acq), .done_pulse(done_pulse), .error(error),
    .cur_rate(cur_rate)
  );

  always #5 ti_clk = ~ti_clk;

  typedef struct {
    logic [4:0] sel; logic [8:0] mc; logic [8:0] dc; int mode;
    logic [8:0] m; logic [8:0] d; logic err; logic [4:0] cur; int trigs; int dones;
  } vec_t;

  int n_cmp = 0, n_fail = 0;
  int cyc = 0, gcnt = 0, gen_mode = 0;
  int trig_cnt = 0, done_cnt = 0, busy_cnt = 0;
  int last_trig = -1, min_gap = 1000000, done_cyc = 0, lock_rise_cyc = 0;
  vec_t sb[$];
  vec_t tbl[8];

  // Generator model: mode 0 normal, 1 never drops PROGDONE, 2 LOCKED glitches after 10 high cycles.
  always @(negedge ti_clk) begin
    cyc++;
    if (reset) begin
      prog_done_in = 1'b1; locked_in = 1'b1; gcnt = 0;
    end else begin
      if (gcnt > 0) begin
        gcnt++;
        if (gcnt == 36) prog_done_in = 1'b1;
        if (gcnt == 40) begin locked_in = 1'b1; lock_rise_cyc = cyc; end
        if (gen_mode == 2 && gcnt == 50) locked_in = 1'b0;
        if (gen_mode == 2 && gcnt == 51) begin locked_in = 1'b1; lock_rise_cyc = cyc; end
        if (gcnt == 60) gcnt = 0;
      end
      if (prog_trigger) begin
        trig_cnt++;
        if (last_trig >= 0 && cyc - last_trig < min_gap) min_gap = cyc - last_trig;
        last_trig = cyc;
        if (gen_mode != 1) begin gcnt = 1; prog_done_in = 1'b0; locked_in = 1'b0; end
      end
      if (done_pulse) begin done_cnt++; done_cyc = cyc; end
      if (busy) busy_cnt++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 20000) begin @(negedge ti_clk); n++; end
    chk("idle_bound", {31'd0, busy}, 0);
  endtask

  task automatic run_vec(input vec_t v);
    int t0, d0;
    vec_t e;
    gen_mode = v.mode; t0 = trig_cnt; d0 = done_cnt; min_gap = 1000000; last_trig = -1;
    rate_sel = v.sel; M_custom = v.mc; D_custom = v.dc; rate_go = 1'b1;
    sb.push_back(v);
    @(negedge ti_clk); rate_go = 1'b0;
    wait_idle();
    e = sb.pop_front();
    chk("vec_m", M_out, e.m);
    chk("vec_d", D_out, e.d);
    chk("vec_err", error, e.err);
    chk("vec_cur", cur_rate, e.cur);
    chk("vec_trigs", trig_cnt - t0, e.trigs);
    chk("vec_dones", done_cnt - d0, e.dones);
    if (e.trigs > 1) chk("trig_gap_ge_4096", min_gap >= 4096, 1);
    if (e.dones == 1) chk("lock_to_done", done_cyc - lock_rise_cyc, 18);
    @(negedge ti_clk);
  endtask

  initial begin
    int t0, d0, b0, n;
    tbl[0] = '{5'd0,  9'd0,   9'd0,  0, 9'd7,   9'd125, 1'b0, 5'd0,  1, 1};
    tbl[1] = '{5'd20, 9'd0,   9'd0,  0, 9'd7,   9'd125, 1'b1, 5'd0,  0, 0};
    tbl[2] = '{5'd10, 9'd0,   9'd0,  0, 9'd112, 9'd250, 1'b0, 5'd10, 1, 1};
    tbl[3] = '{5'd19, 9'd0,   9'd0,  2, 9'd14,  9'd5,   1'b0, 5'd19, 1, 1};
    tbl[4] = '{5'd31, 9'd200, 9'd10, 0, 9'd14,  9'd5,   1'b1, 5'd19, 0, 0};
    tbl[5] = '{5'd2,  9'd0,   9'd0,  1, 9'd21,  9'd250, 1'b1, 5'd19, 3, 0};
`ifdef CLKGEN_CUSTOM_MD_EN
    tbl[6] = '{5'd31, 9'd30,  9'd20, 0, 9'd30,  9'd20,  1'b0, 5'd31, 1, 1};
    tbl[7] = '{5'd16, 9'd0,   9'd0,  0, 9'd42,  9'd25,  1'b0, 5'd16, 1, 1};
`else
    tbl[6] = '{5'd31, 9'd30,  9'd20, 0, 9'd21,  9'd250, 1'b1, 5'd19, 0, 0};
    tbl[7] = '{5'd16, 9'd0,   9'd0,  0, 9'd42,  9'd25,  1'b0, 5'd16, 1, 1};
`endif

    repeat (3) @(negedge ti_clk);
    chk("rst_m", M_out, 42);
    chk("rst_d", D_out, 25);
    chk("rst_cur", cur_rate, 16);
    chk("rst_busy", {busy, hold_acq, prog_trigger, done_pulse, error}, 0);
    reset = 1'b0;
    @(negedge ti_clk);

    // Invalid index straight after reset.
    t0 = trig_cnt; b0 = busy_cnt;
    rate_sel = 5'd25; rate_go = 1'b1;
    @(negedge ti_clk); rate_go = 1'b0;
    chk("inv_err", error, 1);
    chk("inv_busy", busy, 1);
    @(negedge ti_clk);
    chk("inv_busy_end", busy, 0);
    chk("inv_busy_cycles", busy_cnt - b0, 1);
    chk("inv_trigs", trig_cnt - t0, 0);
    chk("inv_m", M_out, 42);
    chk("inv_d", D_out, 25);
    chk("inv_cur", cur_rate, 16);

    // Index 11: latency of M/D, busy and the trigger pulse.
    t0 = trig_cnt; d0 = done_cnt;
    rate_sel = 5'd11; rate_go = 1'b1;
    @(negedge ti_clk); rate_go = 1'b0;
    chk("t1_busy", {busy, hold_acq}, 2'b11);
    chk("t1_m", M_out, 14);
    chk("t1_d", D_out, 25);
    chk("t1_trig", prog_trigger, 0);
    chk("t1_err_clr", error, 0);
    @(negedge ti_clk);
    chk("t2_trig", prog_trigger, 1);
    @(negedge ti_clk);
    chk("t3_trig", prog_trigger, 0);
    wait_idle();
    chk("r11_trigs", trig_cnt - t0, 1);
    chk("r11_dones", done_cnt - d0, 1);
    chk("r11_lock_to_done", done_cyc - lock_rise_cyc, 18);
    chk("r11_cur", cur_rate, 11);
    @(negedge ti_clk);

    // Requests while busy and coincident with DONE are ignored.
    d0 = done_cnt;
    rate_sel = 5'd19; rate_go = 1'b1;
    @(negedge ti_clk); rate_go = 1'b0;
    repeat (5) @(negedge ti_clk);
    rate_sel = 5'd3; rate_go = 1'b1;
    @(negedge ti_clk); rate_go = 1'b0;
    chk("bb_m", M_out, 14);
    chk("bb_d", D_out, 5);
    n = 0;
    while (!done_pulse && n < 20000) begin @(negedge ti_clk); n++; end
    chk("bb_done_seen", done_pulse, 1);
    chk("bb_m_at_done", M_out, 14);
    rate_sel = 5'd3; rate_go = 1'b1;
    @(negedge ti_clk); rate_go = 1'b0;
    chk("done_go_ignored", busy, 0);
    chk("bb_cur", cur_rate, 19);
    chk("bb_d_end", D_out, 5);
    chk("bb_dones", done_cnt - d0, 1);

    // Reset mid-sequence with a simultaneous request.
    rate_sel = 5'd5; rate_go = 1'b1;
    @(negedge ti_clk); rate_go = 1'b0;
    repeat (10) @(negedge ti_clk);
    reset = 1'b1; rate_sel = 5'd7; rate_go = 1'b1;
    @(negedge ti_clk); reset = 1'b0; rate_go = 1'b0;
    chk("mid_rst_outs", {busy, hold_acq, prog_trigger, done_pulse, error}, 0);
    chk("mid_rst_m", M_out, 42);
    chk("mid_rst_d", D_out, 25);
    chk("mid_rst_cur", cur_rate, 16);
    @(negedge ti_clk);
    chk("mid_rst_go_dropped", busy, 0);

    for (int i = 0; i < 8; i++) run_vec(tbl[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
